// File: rtl/clock_pkg.sv
// Shared encodings and field limits for the clock timekeeping/set controller.
package clock_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_ILLEGAL  = 2'd3
    } mode_e;

    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;

endpackage

// File: rtl/tick_gen.sv
// Divider with enable and synchronous clear; strobe is high for the one cycle
// in which the counter sits at DIV-1 while enabled (it wraps on that same edge).
module tick_gen #(
    parameter int DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic strobe
);

    localparam int DIV_E = (DIV < 1) ? 1 : DIV;
    localparam int W     = (DIV_E > 1) ? $clog2(DIV_E) : 1;
    localparam logic [W-1:0] LAST = W'(DIV_E - 1);

    logic [W-1:0] cnt;
    logic         at_last;

    assign at_last = (cnt == LAST);
    // A clear in the same cycle suppresses the strobe, so a due tick is dropped.
    assign strobe  = en && !clr && at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// HH:MM:SS timekeeper with a RUN / SET_HOUR / SET_MIN mode machine driven by
// debounced button pulses; all outputs registered.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BLINK_DIV = CLK_HZ / 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn_mode,
    input  logic                btn_up,
    input  logic                btn_down,
    output logic [HOUR_W-1:0]   hour,
    output logic [MIN_W-1:0]    min,
    output logic [SEC_W-1:0]    sec,
    output logic [MODE_W-1:0]   mode,
    output logic                blink
);

    mode_e state, state_nxt;
    logic  in_run, in_set, set_hour, set_min;
    logic  mode_chg, leave_set, adj_up, adj_dn, blink_force;
    logic  tick, blink_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MODE_RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MODE_RUN:      if (btn_mode) state_nxt = MODE_SET_HOUR;
            MODE_SET_HOUR: if (btn_mode) state_nxt = MODE_SET_MIN;
            MODE_SET_MIN:  if (btn_mode) state_nxt = MODE_RUN;
            default:       state_nxt = MODE_RUN;
        endcase
    end

    always_comb begin
        in_run      = (state == MODE_RUN);
        set_hour    = (state == MODE_SET_HOUR);
        set_min     = (state == MODE_SET_MIN);
        in_set      = set_hour || set_min;
        mode_chg    = (state_nxt != state);
        leave_set   = set_min && btn_mode;
        // Mode pulse takes priority; opposing up+down cancel out.
        adj_up      = in_set && !btn_mode && btn_up && !btn_down;
        adj_dn      = in_set && !btn_mode && btn_down && !btn_up;
        blink_force = mode_chg || (in_set && (btn_up || btn_down));
    end

    assign mode = state;

    tick_gen #(.DIV(CLK_HZ)) u_sec_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (in_run),
        .clr    (!in_run || btn_mode),
        .strobe (tick)
    );

    tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (in_set),
        .clr    (!in_set || blink_force),
        .strobe (blink_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink <= 1'b1;
        end else if (!in_set || blink_force) begin
            blink <= 1'b1;
        end else if (blink_tick) begin
            blink <= !blink;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hour <= '0;
            min  <= '0;
            sec  <= '0;
        end else if (leave_set) begin
            sec <= '0;
        end else if (tick) begin
            if (sec >= SEC_MAX) begin
                sec <= '0;
                if (min >= MIN_MAX) begin
                    min  <= '0;
                    hour <= (hour >= HOUR_MAX) ? '0 : hour + 1'b1;
                end else begin
                    min <= min + 1'b1;
                end
            end else begin
                sec <= sec + 1'b1;
            end
        end else begin
            if (set_hour && adj_up) hour <= (hour >= HOUR_MAX) ? '0 : hour + 1'b1;
            if (set_hour && adj_dn) hour <= (hour == '0) ? HOUR_MAX : hour - 1'b1;
            if (set_min  && adj_up) min  <= (min >= MIN_MAX) ? '0 : min + 1'b1;
            if (set_min  && adj_dn) min  <= (min == '0) ? MIN_MAX : min - 1'b1;
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed and random button traffic against a seconds-of-day reference model.
module tb_clock_set_ctrl;

    localparam int CLK_HZ    = 8;
    localparam int BLINK_DIV = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [1:0] mode;
    logic       blink;

    int n_chk = 0;
    int n_pass = 0;

    // Reference state: time of day in seconds, mode, cycles into the current
    // second, cycles since blink was last forced visible.
    int m_t, m_md, m_ph, m_since;

    clock_set_ctrl #(.CLK_HZ(CLK_HZ), .BLINK_DIV(BLINK_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_mode (btn_mode),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .hour     (hour),
        .min      (min),
        .sec      (sec),
        .mode     (mode),
        .blink    (blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_t = 0; m_md = 0; m_ph = 0; m_since = 0;
    endtask

    task automatic model_edge(input bit m, input bit u, input bit d);
        int h, mi, s, delta;
        if (m) begin
            if (m_md == 2) m_t = m_t - (m_t % 60);
            m_md = (m_md + 1) % 3;
            m_ph = 0;
            m_since = 0;
        end else if (m_md == 0) begin
            m_ph++;
            if (m_ph == CLK_HZ) begin
                m_ph = 0;
                m_t = (m_t + 1) % 86400;
            end
        end else begin
            m_since++;
            if (u || d) m_since = 0;
            delta = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
            h  = m_t / 3600;
            mi = (m_t / 60) % 60;
            s  = m_t % 60;
            if (m_md == 1) h  = (h + delta + 24) % 24;
            else           mi = (mi + delta + 60) % 60;
            m_t = h * 3600 + mi * 60 + s;
        end
    endtask

    task automatic chk_model(input string where);
        int exp_blink;
        exp_blink = (m_md == 0) ? 1 : ((((m_since / BLINK_DIV) % 2) == 0) ? 1 : 0);
        chk({where, ".hour"},  int'(hour),  m_t / 3600);
        chk({where, ".min"},   int'(min),   (m_t / 60) % 60);
        chk({where, ".sec"},   int'(sec),   m_t % 60);
        chk({where, ".mode"},  int'(mode),  m_md);
        chk({where, ".blink"}, int'(blink), exp_blink);
    endtask

    task automatic cyc(input bit m, input bit u, input bit d);
        btn_mode = m; btn_up = u; btn_down = d;
        @(posedge clk);
        model_edge(m, u, d);
        @(negedge clk);
        btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        chk_model("cyc");
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_vals(input string where);
        chk({where, ".hour"},  int'(hour),  0);
        chk({where, ".min"},   int'(min),   0);
        chk({where, ".sec"},   int'(sec),   0);
        chk({where, ".mode"},  int'(mode),  0);
        chk({where, ".blink"}, int'(blink), 1);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // First second lands exactly CLK_HZ edges after release.
        idle(CLK_HZ - 1);
        chk("first_sec_early", int'(sec), 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("first_sec", int'(sec), 1);

        // Freeze: enter SET_HOUR at sec=5, time stands still.
        idle(4 * CLK_HZ);
        chk("sec_before_set", int'(sec), 5);
        cyc(1'b1, 1'b0, 1'b0);
        idle(40);
        chk("frozen_sec", int'(sec), 5);
        chk("frozen_mode", int'(mode), 1);

        // Hour wrap in both directions.
        cyc(1'b0, 1'b0, 1'b1);
        chk("hour_dn_wrap", int'(hour), 23);
        cyc(1'b0, 1'b1, 1'b0);
        chk("hour_up_wrap", int'(hour), 0);
        chk("blink_after_up", int'(blink), 1);
        cyc(1'b0, 1'b0, 1'b1);

        // Mode beats up; up+down cancels; minute wrap leaves hour alone.
        cyc(1'b1, 1'b1, 1'b0);
        chk("collide_mode", int'(mode), 2);
        chk("collide_hour", int'(hour), 23);
        cyc(1'b0, 1'b1, 1'b1);
        chk("updown_min", int'(min), 0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("min_dn_wrap", int'(min), 59);
        chk("min_wrap_hour", int'(hour), 23);
        idle(3);

        // Exit to RUN clears sec; next second a full period later.
        cyc(1'b1, 1'b0, 1'b0);
        chk("exit_mode", int'(mode), 0);
        chk("exit_sec", int'(sec), 0);
        idle(CLK_HZ - 1);
        chk("resume_early", int'(sec), 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("resume_sec", int'(sec), 1);

        // Day rollover in a single edge.
        idle(58 * CLK_HZ);
        chk("pre_roll_sec", int'(sec), 59);
        idle(CLK_HZ - 1);
        chk("pre_roll_hour", int'(hour), 23);
        cyc(1'b0, 1'b0, 1'b0);
        chk("roll_hour", int'(hour), 0);
        chk("roll_min", int'(min), 0);
        chk("roll_sec", int'(sec), 0);

        // Up in RUN does nothing.
        cyc(1'b0, 1'b1, 1'b0);
        chk("run_up_hour", int'(hour), 0);
        chk("run_up_min", int'(min), 0);

        // Build 12:34:56, park in SET_MIN, then yank reset between edges.
        cyc(1'b1, 1'b0, 1'b0);
        repeat (12) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (34) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        idle(56 * CLK_HZ);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("pre_rst_hour", int'(hour), 12);
        chk("pre_rst_min", int'(min), 34);
        chk("pre_rst_sec", int'(sec), 56);
        chk("pre_rst_mode", int'(mode), 2);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random button traffic.
        for (int i = 0; i < 2500; i++) begin
            cyc($urandom_range(0, 19) == 0,
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 5) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
